// File: rtl/menu_mode_controller.sv
// Mode sequencer for the clock UI: walks WAIT_LCD -> NORMAL -> SETUP -> editors,
// gates buttons toward the editors and turns editor commits into one-cycle load strobes.
module menu_mode_controller #(
  parameter int HOLD_CYCLES    = 2000,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcdReady,
  input  logic [4:0]  i_buttons,
  input  logic        i_timeSetFlag,
  input  logic [17:0] i_timeSetData,
  input  logic        i_tzSetFlag,
  input  logic [4:0]  i_tzSetData,
  output logic [3:0]  o_state,
  output logic        o_menuSel,
  output logic [4:0]  o_buttonsOut,
  output logic        o_clockLoad,
  output logic [17:0] o_clockLoadData,
  output logic        o_tzLoad,
  output logic [4:0]  o_tzLoadData
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);

  localparam logic [4:0] BTN_DOWN   = 5'b10000;
  localparam logic [4:0] BTN_UP     = 5'b01000;
  localparam logic [4:0] BTN_CENTER = 5'b00100;
  localparam logic [4:0] BTN_LEFT   = 5'b00010;

  typedef enum logic [3:0] {
    WAIT_LCD = 4'b0000,
    SETUP    = 4'b0100,
    TIME_SET = 4'b0101,
    TZ_SET   = 4'b0110,
    NORMAL   = 4'b1000
  } StateT;

  StateT         r_state;
  logic          r_menuSel;
  logic [4:0]    r_buttonsOut;
  logic          r_clockLoad;
  logic [17:0]   r_clockLoadData;
  logic          r_tzLoad;
  logic [4:0]    r_tzLoadData;
  logic [4:0]    r_prevButtons;
  logic [HW-1:0] r_holdCount;
  logic [IW-1:0] r_idleCount;
  logic          r_armed;
  logic          r_prevTimeFlag;
  logic          r_prevTzFlag;

  logic [4:0]    w_rise;
  logic          w_timeCommit;
  logic          w_tzCommit;
  logic          w_editing;
  logic          w_idleExpire;
  logic [IW-1:0] w_idleNext;

  assign w_rise       = i_buttons & ~r_prevButtons;
  assign w_timeCommit = i_timeSetFlag & ~r_prevTimeFlag;
  assign w_tzCommit   = i_tzSetFlag & ~r_prevTzFlag;
  assign w_editing    = (r_state == TIME_SET) || (r_state == TZ_SET);
  // Any button rising edge counts as activity and holds off the timeout.
  assign w_idleExpire = (w_rise == 5'b0) && (r_idleCount == IDLE_MAX);
  assign w_idleNext   = (w_rise != 5'b0) ? '0 : r_idleCount + IW'(1);

  // Defaults clear the counters and strobes; every branch that changes state also disarms the button gate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= WAIT_LCD;
      r_menuSel       <= 1'b0;
      r_buttonsOut    <= '0;
      r_clockLoad     <= 1'b0;
      r_clockLoadData <= '0;
      r_tzLoad        <= 1'b0;
      r_tzLoadData    <= '0;
      r_prevButtons   <= '0;
      r_holdCount     <= '0;
      r_idleCount     <= '0;
      r_armed         <= 1'b0;
      r_prevTimeFlag  <= 1'b0;
      r_prevTzFlag    <= 1'b0;
    end else begin
      r_prevButtons  <= i_buttons;
      r_prevTimeFlag <= i_timeSetFlag;
      r_prevTzFlag   <= i_tzSetFlag;
      r_clockLoad    <= 1'b0;
      r_tzLoad       <= 1'b0;
      r_holdCount    <= '0;
      r_idleCount    <= '0;
      r_armed        <= r_armed | (i_buttons == 5'b0);
      r_buttonsOut   <= (r_armed && w_editing) ? i_buttons : 5'b0;

      case (r_state)
        WAIT_LCD: begin
          if (i_lcdReady) begin
            r_state <= NORMAL;
            r_armed <= 1'b0;
          end
        end
        NORMAL: begin
          if (i_buttons == BTN_CENTER) begin
            if (r_holdCount == HOLD_MAX) begin
              r_state   <= SETUP;
              r_menuSel <= 1'b0;
              r_armed   <= 1'b0;
            end else begin
              r_holdCount <= r_holdCount + HW'(1);
            end
          end
        end
        SETUP: begin
          case (w_rise)
            BTN_UP, BTN_DOWN: r_menuSel <= ~r_menuSel;
            BTN_CENTER: begin
              r_state <= r_menuSel ? TZ_SET : TIME_SET;
              r_armed <= 1'b0;
            end
            BTN_LEFT: begin
              r_state <= NORMAL;
              r_armed <= 1'b0;
            end
            default: begin
              if (w_idleExpire) begin
                r_state <= NORMAL;
                r_armed <= 1'b0;
              end else begin
                r_idleCount <= w_idleNext;
              end
            end
          endcase
        end
        TIME_SET: begin
          if (w_timeCommit) begin
            r_clockLoadData <= i_timeSetData;
            r_clockLoad     <= 1'b1;
            r_state         <= NORMAL;
            r_armed         <= 1'b0;
            r_buttonsOut    <= '0;
          end else if (w_idleExpire) begin
            r_state      <= NORMAL;
            r_armed      <= 1'b0;
            r_buttonsOut <= '0;
          end else begin
            r_idleCount <= w_idleNext;
          end
        end
        TZ_SET: begin
          if (w_tzCommit) begin
            r_tzLoadData <= i_tzSetData;
            r_tzLoad     <= 1'b1;
            r_state      <= NORMAL;
            r_armed      <= 1'b0;
            r_buttonsOut <= '0;
          end else if (w_idleExpire) begin
            r_state      <= NORMAL;
            r_armed      <= 1'b0;
            r_buttonsOut <= '0;
          end else begin
            r_idleCount <= w_idleNext;
          end
        end
        default: begin
          r_state <= WAIT_LCD;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign o_state         = r_state;
  assign o_menuSel       = r_menuSel;
  assign o_buttonsOut    = r_buttonsOut;
  assign o_clockLoad     = r_clockLoad;
  assign o_clockLoadData = r_clockLoadData;
  assign o_tzLoad        = r_tzLoad;
  assign o_tzLoadData    = r_tzLoadData;

endmodule

// File: tb/tb_menu_mode_controller.sv
// Bench for menu_mode_controller: mode walk-through, button gating, commits,
// idle timeout and reset, with load strobes checked against a queue of expected loads.
module tb_menu_mode_controller;

  localparam int HOLD = 4;
  localparam int TMO  = 16;

  localparam logic [4:0] B_NONE   = 5'b00000;
  localparam logic [4:0] B_DOWN   = 5'b10000;
  localparam logic [4:0] B_UP     = 5'b01000;
  localparam logic [4:0] B_CENTER = 5'b00100;
  localparam logic [4:0] B_LEFT   = 5'b00010;
  localparam logic [4:0] B_RIGHT  = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic        lcdReady;
  logic [4:0]  buttons;
  logic        timeFlag;
  logic [17:0] timeData;
  logic        tzFlag;
  logic [4:0]  tzData;
  logic [3:0]  state;
  logic        menuSel;
  logic [4:0]  buttonsOut;
  logic        clockLoad;
  logic [17:0] clockLoadData;
  logic        tzLoad;
  logic [4:0]  tzLoadData;

  typedef struct {
    bit          isTz;
    logic [17:0] data;
  } ExpLoad;

  ExpLoad expQ[$];
  ExpLoad expHead;
  int     checkCount = 0;
  int     errorCount = 0;

  menu_mode_controller #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_lcdReady     (lcdReady),
    .i_buttons      (buttons),
    .i_timeSetFlag  (timeFlag),
    .i_timeSetData  (timeData),
    .i_tzSetFlag    (tzFlag),
    .i_tzSetData    (tzData),
    .o_state        (state),
    .o_menuSel      (menuSel),
    .o_buttonsOut   (buttonsOut),
    .o_clockLoad    (clockLoad),
    .o_clockLoadData(clockLoadData),
    .o_tzLoad       (tzLoad),
    .o_tzLoadData   (tzLoadData)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] b, input int n);
    buttons = b;
    step(n);
  endtask

  task automatic enterSetup();
    applyStimulus(B_CENTER, HOLD);
    applyStimulus(B_NONE, 1);
  endtask

  task automatic pushLoad(input bit isTz, input logic [17:0] data);
    ExpLoad e;
    e.isTz = isTz;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Every strobe cycle consumes exactly one expected load; a stretched or unexpected strobe finds nothing.
  always @(negedge clk) begin
    if (clockLoad || tzLoad) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpLoad", {30'b0, clockLoad, tzLoad}, 32'b0);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("loadKind", {30'b0, clockLoad, tzLoad}, expHead.isTz ? 32'b01 : 32'b10);
        checkOutput("loadData", expHead.isTz ? {27'b0, tzLoadData} : {14'b0, clockLoadData},
                    {14'b0, expHead.data});
      end
    end
  end

  initial begin
    reset    = 1'b1;
    lcdReady = 1'b0;
    buttons  = B_NONE;
    timeFlag = 1'b0;
    timeData = '0;
    tzFlag   = 1'b0;
    tzData   = '0;
    step(2);
    checkOutput("rstState", state, 4'b0000);
    checkOutput("rstMenuSel", menuSel, 0);
    checkOutput("rstButtonsOut", buttonsOut, 0);
    checkOutput("rstClockData", clockLoadData, 0);

    reset = 1'b0;
    step(3);
    checkOutput("waitLcd", state, 4'b0000);
    lcdReady = 1'b1;
    step(1);
    checkOutput("lcdReady", state, 4'b1000);
    lcdReady = 1'b0;
    step(1);
    checkOutput("lcdDrop", state, 4'b1000);

    applyStimulus(B_CENTER, HOLD - 1);
    applyStimulus(B_NONE, 2);
    checkOutput("shortHold", state, 4'b1000);

    applyStimulus(B_CENTER, HOLD);
    checkOutput("longHold", state, 4'b0100);
    checkOutput("setupMenuSel", menuSel, 0);
    applyStimulus(B_NONE, 1);

    applyStimulus(B_DOWN, 1);
    applyStimulus(B_NONE, 1);
    checkOutput("downToggle", menuSel, 1);
    checkOutput("setupGate", buttonsOut, 0);
    applyStimulus(B_UP, 1);
    applyStimulus(B_NONE, 1);
    checkOutput("upToggle", menuSel, 0);
    applyStimulus(B_DOWN, 1);
    applyStimulus(B_NONE, 1);

    // CENTER rises on entry, stays held two more cycles, released: idle counter ends at 3.
    applyStimulus(B_CENTER, 3);
    checkOutput("tzEnter", state, 4'b0110);
    checkOutput("heldGate", buttonsOut, 0);
    applyStimulus(B_NONE, 1);
    checkOutput("releaseGate", buttonsOut, 0);
    applyStimulus(B_RIGHT, 1);
    checkOutput("mirror", buttonsOut, B_RIGHT);
    applyStimulus(B_NONE, 1);
    checkOutput("mirrorRelease", buttonsOut, 0);

    // RIGHT rise cleared the idle counter and the release made it 1; 14 more idle cycles reach 15.
    step(TMO - 2);
    checkOutput("preTimeout", state, 4'b0110);
    tzFlag = 1'b1;
    tzData = 5'h1B;
    pushLoad(1'b1, 18'h1B);
    step(1);
    checkOutput("tzCommitState", state, 4'b1000);
    checkOutput("tzCommitData", tzLoadData, 5'h1B);
    tzFlag = 1'b0;
    step(1);

    enterSetup();
    checkOutput("reentryMenu", menuSel, 0);
    applyStimulus(B_CENTER, 1);
    checkOutput("timeEnter", state, 4'b0101);
    applyStimulus(B_NONE, 1);
    timeData = 18'h0C2D7;
    timeFlag = 1'b1;
    pushLoad(1'b0, 18'h0C2D7);
    step(1);
    checkOutput("timeCommitState", state, 4'b1000);
    checkOutput("clockLoadHigh", clockLoad, 1);
    checkOutput("clockLoadData", clockLoadData, 18'h0C2D7);
    step(1);
    checkOutput("strobeWidth", clockLoad, 0);

    // Flag is still high on entry, so only the idle timeout can leave.
    enterSetup();
    applyStimulus(B_CENTER, 1);
    checkOutput("staleEnter", state, 4'b0101);
    applyStimulus(B_NONE, TMO - 2);
    checkOutput("staleNoLoad", state, 4'b0101);
    step(1);
    checkOutput("idleBoundary", state, 4'b0101);
    step(1);
    checkOutput("timeout", state, 4'b1000);
    checkOutput("dataHeld", clockLoadData, 18'h0C2D7);
    timeFlag = 1'b0;

    enterSetup();
    applyStimulus(B_LEFT, 1);
    checkOutput("leftExit", state, 4'b1000);
    applyStimulus(B_NONE, 1);

    enterSetup();
    applyStimulus(B_DOWN, 1);
    applyStimulus(B_NONE, 1);
    applyStimulus(B_CENTER, 1);
    applyStimulus(B_NONE, 1);
    checkOutput("tzEnter2", state, 4'b0110);
    tzFlag = 1'b1;
    reset  = 1'b1;
    step(1);
    checkOutput("midReset", state, 4'b0000);
    checkOutput("midResetLoad", tzLoad, 0);
    checkOutput("midResetData", tzLoadData, 0);
    reset  = 1'b0;
    tzFlag = 1'b0;
    step(2);
    checkOutput("postReset", state, 4'b0000);

    checkOutput("sbEmpty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
